button_event_scheduler: RTL and testbench
=========================================

Name: button_event_scheduler

Overview:
- Collects debounced levels from N Debounce instances; detects press/release edges per button.
- Queues one pending event per kind per button; shares a single event output between the buttons with a round-robin arbiter.
- Output uses a valid/ready handshake to the downstream command FSM.
- Sits directly after the Debounce bank in the 100 MHz clock domain.

Parameters:
- N_BTN, 4, number of debounced button inputs (2..16)
- ID_W, $clog2(N_BTN), width of evt_id
- HOLD_CYCLES, 50_000_000, cycles held before first REPEAT (0.5 s @100 MHz); used only with AUTOREPEAT_EN
- REPEAT_CYCLES, 10_000_000, cycles between subsequent REPEATs; used only with AUTOREPEAT_EN

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- btn_db  in  N_BTN  debounced button levels, 1 = pressed; synchronous to clk
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready
- evt_id  out  ID_W  index of the button that produced the event
- evt_kind  out  2  00 PRESS, 01 RELEASE, 10 REPEAT, 11 reserved
- overflow  out  1  sticky; set when an edge is dropped

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - evt_valid=0, evt_id=0, evt_kind=0, overflow=0.
  - All pending flags=0; rr pointer=0.
  - prev_q <= btn_db, so a button held through reset produces no PRESS.
- Edge detect:
  - rise = btn_db & ~prev_q sets pend_press[i].
  - fall = ~btn_db & prev_q sets pend_rel[i].
  - prev_q <= btn_db every cycle.
- Drop rule: an edge arriving while the same-kind flag is already set is dropped, and overflow is set. overflow clears only on reset.
- Per-button request: req[i] = pend_press[i] | pend_rel[i] | pend_rep[i]. Priority within a button is PRESS > RELEASE > REPEAT.
- Arbiter: round-robin, starting at ptr. The first i with req[i] wins.
- Output register load:
  - Loads when (!evt_valid || evt_ready) && |req.
  - The winner's selected flag clears in that same cycle; ptr <= winner+1, wrapping modulo N_BTN.
  - An edge in the load cycle for the flag being cleared re-sets that flag (set wins over clear). No overflow is raised in that case.
- Handshake:
  - evt_id/evt_kind are stable while evt_valid && !evt_ready.
  - On accept with no request, evt_valid <= 0.
  - Back-to-back throughput is one event per cycle.
- Latency: btn_db edge sampled in cycle t, pending flag in t+1, evt_valid in t+2 if the output is free and no other requester wins.
- Mid-operation reset: any event in flight is lost and all state returns to reset values. No event is emitted in the reset cycle.

Optional Feature:
- Macro: BUTTON_EVENT_AUTOREPEAT_EN.
- Defined:
  - Each button has a hold counter of width $clog2(HOLD_CYCLES+1). It clears on a rise and while the button is released.
  - The counter increments while held. On reaching HOLD_CYCLES it sets pend_rep[i] and reloads to HOLD_CYCLES-REPEAT_CYCLES, so subsequent REPEATs come every REPEAT_CYCLES.
  - A REPEAT while pend_rep[i] is set is dropped silently; overflow is not set.
  - A fall clears the counter and any not-yet-loaded pend_rep[i].
- Undefined: no counters and no pend_rep; evt_kind is never 10.

Decomposition:
- Package button_evt_pkg:
  - typedef enum logic[1:0] evt_kind_t {EVT_PRESS, EVT_RELEASE, EVT_REPEAT}
  - default timing constants HOLD_CYCLES_DEF, REPEAT_CYCLES_DEF
- Sub-module rr_arbiter: parameter N; inputs req[N], ptr; outputs grant_idx, grant_any. Purely combinational; the pointer register lives in the parent.

Test Plan (N_BTN=4; HOLD_CYCLES=20 and REPEAT_CYCLES=5 where the macro is defined):
1. Single press/release: btn_db[2] 0->1 at cycle 10, evt_ready=1. Expect evt_valid at cycle 12 with id=2, kind=PRESS. Then 1->0 gives id=2, kind=RELEASE two cycles later. overflow stays 0.
2. Simultaneous edges:
   - btn_db 0000->1011 in one cycle, ready=1. Expect PRESS ids 0, 1, 3 on consecutive cycles.
   - Then with ptr=0, btn_db[1] and btn_db[0] fall together. Expect RELEASE id=0 then id=1.
3. Backpressure: evt_ready=0 while pressing buttons 1 and 2. evt_valid holds id=1/PRESS unchanged for 10 cycles. Raising ready yields id=2 on the next cycle.
4. Overflow: ready=0; toggle btn_db[0] 0->1->0->1. The second rise is dropped and overflow=1. After ready=1, exactly PRESS, RELEASE for id 0 are emitted.
5. Reset:
   - Assert reset for 1 cycle while evt_valid=1 and btn_db[3]=1. All outputs are 0 the next cycle; no PRESS for button 3 afterwards.
   - A later fall on button 3 yields RELEASE id=3.
6. With BUTTON_EVENT_AUTOREPEAT_EN: hold btn_db[1] for 40 cycles. Expect PRESS, then REPEAT at held-cycle 20, 25, 30, 35, then RELEASE on the fall. Without the macro, the same stimulus gives only PRESS and RELEASE.

Source files
------------

// File: rtl/button_evt_pkg.sv
// Shared types and default timing for the button event scheduler.
package button_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_REPEAT  = 2'b10
    } evt_kind_t;

    // 0.5 s initial hold and 0.1 s repeat period at 100 MHz.
    localparam int HOLD_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // Scan from the farthest candidate back to ptr so the nearest one is written last.
    always_comb begin
        int j;
        j         = 0;
        grant_idx = '0;
        grant_any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) grant_idx = IDX_W'(j);
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Edge-to-event scheduler for a debounced button bank with a valid/ready output.
// Optional auto-repeat while held is enabled by defining BUTTON_EVENT_AUTOREPEAT_EN.
module button_event_scheduler
    import button_evt_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int ID_W          = $clog2(N_BTN),
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_db,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic [1:0]       evt_kind,
    output logic             overflow
);

    if (N_BTN < 2 || N_BTN > 16 || ID_W < $clog2(N_BTN) ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_cfg
        $error("button_event_scheduler: invalid parameter set");
    end

    logic [N_BTN-1:0] prev_q;
    logic [N_BTN-1:0] pend_press;
    logic [N_BTN-1:0] pend_rel;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] req;
    logic [N_BTN-1:0] clr_press;
    logic [N_BTN-1:0] clr_rel;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic             win_any;
    logic             load;
    evt_kind_t        win_kind;

`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [CNT_W-1:0] hold_cnt [N_BTN];
    logic [N_BTN-1:0] pend_rep;
    logic [N_BTN-1:0] rep_hit;
    logic [N_BTN-1:0] clr_rep;
`endif

    assign rise = btn_db & ~prev_q;
    assign fall = ~btn_db & prev_q;
    assign load = (!evt_valid || evt_ready) && win_any;

`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    assign req = pend_press | pend_rel | pend_rep;
`else
    assign req = pend_press | pend_rel;
`endif

    rr_arbiter #(
        .N     (N_BTN),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant_idx (win),
        .grant_any (win_any)
    );

    // Within the winning button PRESS beats RELEASE beats REPEAT; only the chosen flag clears.
    always_comb begin
        clr_press = '0;
        clr_rel   = '0;
        win_kind  = EVT_PRESS;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        clr_rep   = '0;
`endif
        if (pend_press[win]) begin
            win_kind       = EVT_PRESS;
            clr_press[win] = load;
        end else if (pend_rel[win]) begin
            win_kind     = EVT_RELEASE;
            clr_rel[win] = load;
        end
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        else begin
            win_kind     = EVT_REPEAT;
            clr_rep[win] = load;
        end
`endif
    end

    // prev_q tracks the input even in reset so a button held through reset raises no PRESS.
    always_ff @(posedge clk) begin
        prev_q <= btn_db;
        if (reset) begin
            pend_press <= '0;
            pend_rel   <= '0;
            ptr        <= '0;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_kind   <= EVT_PRESS;
            overflow   <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | rise;
            pend_rel   <= (pend_rel & ~clr_rel) | fall;
            if (|(rise & pend_press & ~clr_press) || |(fall & pend_rel & ~clr_rel))
                overflow <= 1'b1;
            if (load) begin
                evt_valid <= 1'b1;
                evt_id    <= win;
                evt_kind  <= win_kind;
                ptr       <= (win == ID_W'(N_BTN - 1)) ? '0 : win + 1'b1;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < N_BTN; i++)
            rep_hit[i] = btn_db[i] & prev_q[i] & (hold_cnt[i] == HOLD_MAX - 1'b1);
    end

    // Reloading to HOLD-REPEAT makes every later REPEAT land REPEAT_CYCLES apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rep <= '0;
            for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
        end else begin
            pend_rep <= ((pend_rep & ~clr_rep) | rep_hit) & ~fall;
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_db[i] || rise[i])
                    hold_cnt[i] <= '0;
                else if (rep_hit[i])
                    hold_cnt[i] <= RELOAD;
                else
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler: directed vectors plus random run vs. an event model.
module tb_button_event_scheduler;

    localparam int N     = 4;
    localparam int HOLD  = 20;
    localparam int REP   = 5;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_db;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_id;
    logic [1:0]   evt_kind;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    button_event_scheduler #(
        .N_BTN         (N),
        .ID_W          (2),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_db    (btn_db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_kind  (evt_kind),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Event-level reference: pending set per button and kind, hold time in cycles.
    bit m_last [N];
    bit m_pp   [N];
    bit m_pr   [N];
    bit m_prep [N];
    int m_held [N];
    int m_rr;
    bit m_valid;
    int m_id;
    int m_kind;
    bit m_ovf;

    task automatic model_step(input logic [N-1:0] b, input logic rdy, input logic rs);
        int  win;
        int  wk;
        bit  ld;
        if (rs) begin
            for (int i = 0; i < N; i++) begin
                m_pp[i] = 0; m_pr[i] = 0; m_prep[i] = 0; m_held[i] = 0; m_last[i] = b[i];
            end
            m_rr = 0; m_valid = 0; m_id = 0; m_kind = 0; m_ovf = 0;
            return;
        end
        win = -1;
        wk  = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (win < 0 && (m_pp[j] || m_pr[j] || m_prep[j])) win = j;
        end
        ld = (!m_valid || rdy) && (win >= 0);
        if (ld) begin
            if (m_pp[win])      begin wk = 0; m_pp[win] = 0; end
            else if (m_pr[win]) begin wk = 1; m_pr[win] = 0; end
            else                begin wk = 2; m_prep[win] = 0; end
        end
        for (int i = 0; i < N; i++) begin
            if (b[i] && !m_last[i]) begin
                if (m_pp[i]) m_ovf = 1;
                m_pp[i] = 1;
                m_held[i] = 0;
            end else if (!b[i] && m_last[i]) begin
                if (m_pr[i]) m_ovf = 1;
                m_pr[i] = 1;
                m_prep[i] = 0;
                m_held[i] = 0;
            end else if (b[i]) begin
                m_held[i]++;
                if (AUTOREP && m_held[i] >= HOLD && (m_held[i] - HOLD) % REP == 0) m_prep[i] = 1;
            end else begin
                m_held[i] = 0;
            end
            m_last[i] = b[i];
        end
        if (ld) begin
            m_valid = 1; m_id = win; m_kind = wk; m_rr = (win + 1) % N;
        end else if (rdy) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [31:0] pk(input int v, input int id, input int k, input int o);
        return 32'(v * 32 + id * 8 + k * 2 + o);
    endfunction

    function automatic logic [31:0] obs();
        return {26'd0, evt_valid, evt_id, evt_kind, overflow};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (v,id,kind,ovf packed)", name, got, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] b, input logic rdy, input logic rs);
        btn_db    = b;
        evt_ready = rdy;
        reset     = rs;
        @(posedge clk);
        model_step(b, rdy, rs);
        #1;
        chk("model", obs(), pk(int'(m_valid), m_id, m_kind, int'(m_ovf)));
    endtask

    typedef struct {
        logic [N-1:0] btn;
        logic         rdy;
        logic         rst;
        int           v;
        int           id;
        int           k;
        int           o;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] b, input logic r, input logic s,
                                input int v, input int id, input int k, input int o);
        vec_t t;
        t.btn = b; t.rdy = r; t.rst = s; t.v = v; t.id = id; t.k = k; t.o = o;
        return t;
    endfunction

    vec_t tbl [17];

    initial begin
        int ev_off  [$];
        int ev_kind [$];
        int exp_off [$];
        int exp_kind[$];
        logic [N-1:0] rb;

        tbl[0]  = mk(4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(4'b0100, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(4'b0100, 1, 0, 1, 2, 0, 0);
        tbl[3]  = mk(4'b0100, 1, 0, 0, 2, 0, 0);
        tbl[4]  = mk(4'b0000, 1, 0, 0, 2, 0, 0);
        tbl[5]  = mk(4'b0000, 1, 0, 1, 2, 1, 0);
        tbl[6]  = mk(4'b0000, 1, 0, 0, 2, 1, 0);
        tbl[7]  = mk(4'b0000, 1, 1, 0, 0, 0, 0);
        tbl[8]  = mk(4'b1011, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(4'b1011, 1, 0, 1, 0, 0, 0);
        tbl[10] = mk(4'b1011, 1, 0, 1, 1, 0, 0);
        tbl[11] = mk(4'b1011, 1, 0, 1, 3, 0, 0);
        tbl[12] = mk(4'b1011, 1, 0, 0, 3, 0, 0);
        tbl[13] = mk(4'b1000, 1, 0, 0, 3, 0, 0);
        tbl[14] = mk(4'b1000, 1, 0, 1, 0, 1, 0);
        tbl[15] = mk(4'b1000, 1, 0, 1, 1, 1, 0);
        tbl[16] = mk(4'b1000, 1, 0, 0, 1, 1, 0);

        btn_db = '0; evt_ready = 1'b1; reset = 1'b1;
        step(4'b0000, 1, 1);
        chk("reset_state", obs(), pk(0, 0, 0, 0));

        // Single press/release, then simultaneous edges
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].btn, tbl[i].rdy, tbl[i].rst);
            chk($sformatf("vec%0d", i), obs(), pk(tbl[i].v, tbl[i].id, tbl[i].k, tbl[i].o));
        end

        // Backpressure holds id=1 until ready
        step(4'b0000, 0, 1);
        step(4'b0110, 0, 0);
        chk("bp_idle", obs(), pk(0, 0, 0, 0));
        step(4'b0110, 0, 0);
        chk("bp_first", obs(), pk(1, 1, 0, 0));
        for (int i = 0; i < 10; i++) begin
            step(4'b0110, 0, 0);
            chk($sformatf("bp_hold%0d", i), obs(), pk(1, 1, 0, 0));
        end
        step(4'b0110, 1, 0);
        chk("bp_second", obs(), pk(1, 2, 0, 0));
        step(4'b0110, 1, 0);
        chk("bp_drain", obs(), pk(0, 2, 0, 0));

        // Overflow: output blocked by button 3, button 0 toggles twice
        step(4'b0000, 1, 1);
        step(4'b1000, 0, 0);
        step(4'b1000, 0, 0);
        chk("ovf_block", obs(), pk(1, 3, 0, 0));
        step(4'b1001, 0, 0);
        step(4'b1000, 0, 0);
        chk("ovf_before", obs(), pk(1, 3, 0, 0));
        step(4'b1001, 0, 0);
        chk("ovf_set", obs(), pk(1, 3, 0, 1));
        step(4'b1001, 1, 0);
        chk("ovf_press0", obs(), pk(1, 0, 0, 1));
        step(4'b1001, 1, 0);
        chk("ovf_rel0", obs(), pk(1, 0, 1, 1));
        step(4'b1001, 1, 0);
        chk("ovf_done", obs(), pk(0, 0, 1, 1));

        // Mid-operation reset with button 3 held
        step(4'b0000, 1, 1);
        step(4'b1000, 0, 0);
        step(4'b1000, 0, 0);
        chk("rst_pre", obs(), pk(1, 3, 0, 0));
        step(4'b1000, 0, 1);
        chk("rst_clear", obs(), pk(0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step(4'b1000, 1, 0);
            chk($sformatf("rst_nopress%0d", i), obs(), pk(0, 0, 0, 0));
        end
        step(4'b0000, 1, 0);
        step(4'b0000, 1, 0);
        chk("rst_release3", obs(), pk(1, 3, 1, 0));

        // Hold button 1 for 40 cycles and collect the event stream
        step(4'b0000, 1, 1);
        for (int s = 0; s < 46; s++) begin
            step((s < 40) ? 4'b0010 : 4'b0000, 1, 0);
            if (evt_valid) begin
                ev_off.push_back(s);
                ev_kind.push_back(int'(evt_kind));
            end
        end
        exp_off.push_back(1);  exp_kind.push_back(0);
        if (AUTOREP) begin
            for (int r = 0; r < 4; r++) begin
                exp_off.push_back(21 + r * REP);
                exp_kind.push_back(2);
            end
        end
        exp_off.push_back(41); exp_kind.push_back(1);
        chk("hold_count", 32'(ev_off.size()), 32'(exp_off.size()));
        for (int i = 0; i < exp_off.size() && i < ev_off.size(); i++) begin
            chk($sformatf("hold_off%0d", i), 32'(ev_off[i]), 32'(exp_off[i]));
            chk($sformatf("hold_kind%0d", i), 32'(ev_kind[i]), 32'(exp_kind[i]));
        end

        // Random run against the model
        step(4'b0000, 1, 1);
        rb = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) rb[i] = ~rb[i];
            step(rb, ($urandom_range(0, 9) < 7), ($urandom_range(0, 499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
